reg_file_scoreboard: RTL and testbench
======================================

Name: reg_file_scoreboard

Overview:
Parametrised processor register file with one synchronous writeback port, two bypassed read ports, and a per-register busy scoreboard for pipeline hazard detection. After reset, an init sequencer clears the data array one entry per cycle, so the array can map to RAM. Sits between decode (read and issue) and writeback in the pipelined core. Register 0 is hardwired to zero.

Parameters:
DATA_W, 16, width of each register and of the data ports
ADDR_W, 4, register index width; NUM_REG = 2**ADDR_W (derived localparam, not overridable)

Ports:
clock  in  1  rising-edge clock
reset  in  1  reset, synchronous, active-high
rs1  in  ADDR_W  read index, port 1
rs2  in  ADDR_W  read index, port 2
reg1  out  DATA_W  read data, port 1 (combinational)
reg2  out  DATA_W  read data, port 2 (combinational)
busy1  out  1  scoreboard busy bit of rs1 (combinational)
busy2  out  1  scoreboard busy bit of rs2 (combinational)
wb_en  in  1  writeback enable
rd_wb  in  ADDR_W  writeback destination
wb_data  in  DATA_W  writeback data
issue_en  in  1  instruction issued with destination rd_issue
rd_issue  in  ADDR_W  destination being claimed
ready  out  1  high when the init sweep is done and the block accepts writes and issues
pending  out  ADDR_W+1  number of registers currently marked busy (registered)

Behaviour:
- FSM states:
  - INIT: entered on reset; sweep pointer ptr, ADDR_W bits.
  - RUN: normal operation.
- Reset (sampled on clock edge):
  - state <= INIT, ptr <= 0.
  - All busy bits <= 0, pending <= 0.
  - ready is 0 from the cycle after the reset edge.
  - Reset asserted mid-sweep restarts the sweep at ptr = 0.
  - Reset has priority over every other input.
- INIT:
  - Each cycle: regs[ptr] <= 0, ptr <= ptr + 1.
  - When ptr == NUM_REG-1, state <= RUN.
  - Duration is NUM_REG cycles: ready rises on the edge NUM_REG cycles after reset deasserts.
  - wb_en and issue_en are ignored.
  - reg1, reg2, busy1, busy2 read 0.
- RUN writeback:
  - If wb_en and rd_wb != 0: regs[rd_wb] <= wb_data at the clock edge, and busy[rd_wb] <= 0 unless overridden by an issue (see priority below).
  - wb_en with rd_wb == 0 writes nothing and changes no state.
- RUN issue:
  - If issue_en and rd_issue != 0: busy[rd_issue] <= 1.
  - issue_en with rd_issue == 0 is ignored.
  - Re-issuing a register that is already busy leaves it busy; pending does not change.
- Same-cycle writeback and issue to the same register:
  - Data is written.
  - busy stays/becomes 1 (the new producer wins).
  - pending is unchanged net.
- pending:
  - Next value = current + (busy bit set 0->1) - (busy bit cleared 1->0).
  - Computed from the actual bit transitions; never underflows or overflows; maximum NUM_REG-1.
- Read ports (RUN; rules identical for port 1 and port 2):
  - rsN == 0: regN = 0, busyN = 0.
  - Else if wb_en and rd_wb == rsN: regN = wb_data (write-first bypass) and busyN = 0.
  - Exception: if issue_en and rd_issue == rsN in the same cycle, busyN still reports the pre-edge value of busy[rsN] with the bypass applied.
  - Else regN = regs[rsN], busyN = busy[rsN].
  - Reads never have side effects.
- Width rules:
  - wb_data is stored unmodified.
  - No sign handling; all indices are unsigned.

Test Plan:
- Reset for 1 cycle, then idle -> ready = 0 for exactly 16 cycles (ADDR_W=4), then 1; all reads return 0x0000; pending = 0.
- RUN: wb_en=1, rd_wb=3, wb_data=0xBEEF; rs1=3 in the same cycle -> reg1 = 0xBEEF combinationally; next cycle with wb_en=0, reg1 = 0xBEEF.
- Writeback to R0 with wb_data=0x1234, rs2=0 -> reg2 = 0x0000 and busy2 = 0 both that cycle and the next.
- Issue rd=5, then rd=7 -> pending = 1, then 2; busy1 = 1 at rs1=5. Writeback R5 -> pending = 1; busy1 = 0 in the writeback cycle (bypass).
- Same cycle: issue_en with rd_issue=9 and wb_en with rd_wb=9, data 0x00AA, R9 previously busy -> R9 = 0x00AA, busy[9] stays 1, pending unchanged.
- Assert reset at sweep cycle 8, hold 1 cycle -> sweep restarts; ready rises 16 cycles after reset release; earlier contents (e.g. R3 = 0xBEEF) read 0x0000; writes issued during INIT are dropped.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// Register file with one writeback port, two write-first bypassed read ports
// and a per-register busy scoreboard; an init sweep zeroes the array after reset.
module reg_file_scoreboard #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic              busy1,
  output logic              busy2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] rd_wb,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] rd_issue,
  output logic              ready,
  output logic [ADDR_W:0]   pending
);

  localparam int NUM_REG = 2 ** ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REG-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]     pending_q, pending_d;
  logic [DATA_W-1:0]   regs_q [NUM_REG];

  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic                run;
  logic                wb_hit;
  logic                issue_hit;
  logic                inc;
  logic                dec;

  assign run       = (state_q == RUN);
  assign wb_hit    = run && wb_en && (rd_wb != '0);
  assign issue_hit = run && issue_en && (rd_issue != '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we      = 1'b0;
    waddr   = rd_wb;
    wdata   = wb_data;
    if (state_q == INIT) begin
      we    = 1'b1;
      waddr = ptr_q;
      wdata = '0;
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == ADDR_W'(NUM_REG - 1)) state_d = RUN;
    end else begin
      we = wb_hit;
    end
  end

  // Issue is applied after writeback so a same-cycle new producer keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wb_hit)    busy_d[rd_wb]    = 1'b0;
    if (issue_hit) busy_d[rd_issue] = 1'b1;
    inc       = |(busy_d & ~busy_q);
    dec       = |(busy_q & ~busy_d);
    pending_d = pending_q + (ADDR_W + 1)'(inc) - (ADDR_W + 1)'(dec);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= INIT;
      ptr_q     <= '0;
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  // Data array carries no reset so it can map onto RAM; the sweep clears it.
  always_ff @(posedge clock) begin
    if (!reset && we) regs_q[waddr] <= wdata;
  end

  function automatic logic [DATA_W:0] read_port(
    input logic [ADDR_W-1:0] rs,
    input logic [DATA_W-1:0] stored,
    input logic              stored_busy
  );
    logic [DATA_W:0] r;
    r = '0;
    if (run && rs != '0) begin
      if (wb_en && rd_wb == rs) begin
        r[DATA_W-1:0] = wb_data;
        r[DATA_W]     = (issue_en && rd_issue == rs) ? stored_busy : 1'b0;
      end else begin
        r = {stored_busy, stored};
      end
    end
    return r;
  endfunction

  always_comb begin
    {busy1, reg1} = read_port(rs1, regs_q[rs1], busy_q[rs1]);
    {busy2, reg2} = read_port(rs2, regs_q[rs2], busy_q[rs2]);
  end

  assign ready   = run;
  assign pending = pending_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard with hand-computed expectations.
module tb_reg_file_scoreboard;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] rs1, rs2, rd_wb, rd_issue;
  logic [DATA_W-1:0] reg1, reg2, wb_data;
  logic              busy1, busy2, wb_en, issue_en, ready;
  logic [ADDR_W:0]   pending;

  int n_tests = 0;
  int n_fail  = 0;

  reg_file_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .rs1(rs1), .rs2(rs2), .reg1(reg1), .reg2(reg2),
    .busy1(busy1), .busy2(busy2),
    .wb_en(wb_en), .rd_wb(rd_wb), .wb_data(wb_data),
    .issue_en(issue_en), .rd_issue(rd_issue),
    .ready(ready), .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wb_en = 1'b0; issue_en = 1'b0;
    rd_wb = '0; rd_issue = '0; wb_data = '0;
  endtask

  // Counts edges until ready rises while hammering writes/issues that must be ignored.
  task automatic sweep(output int n);
    n = 0;
    wb_en = 1'b1; rd_wb = 4'd3; wb_data = 16'h5555;
    issue_en = 1'b1; rd_issue = 4'd4;
    rs1 = 4'd3; rs2 = 4'd4;
    while (!ready && n < 40) begin
      #1;
      if (n == 5) begin
        check("init_reg1_zero", 32'(reg1), 32'h0);
        check("init_busy2_zero", 32'(busy2), 32'h0);
      end
      tick();
      n++;
    end
    idle();
  endtask

  int cnt;

  initial begin
    reset = 1'b1; rs1 = '0; rs2 = '0;
    idle();
    tick(); tick();
    reset = 1'b0;
    #1;
    check("ready_low_after_reset", 32'(ready), 32'h0);
    check("pending_reset", 32'(pending), 32'h0);
    sweep(cnt);
    check("sweep_len", 32'(cnt), 32'd16);
    rs1 = 4'd3; rs2 = 4'd15;
    #1;
    check("post_init_r3", 32'(reg1), 32'h0);
    check("post_init_r15", 32'(reg2), 32'h0);
    check("post_init_pending", 32'(pending), 32'h0);
    check("post_init_busy1", 32'(busy1), 32'h0);

    // Write-first bypass then registered read
    wb_en = 1'b1; rd_wb = 4'd3; wb_data = 16'hBEEF; rs1 = 4'd3;
    #1;
    check("bypass_r3", 32'(reg1), 32'hBEEF);
    check("bypass_busy1", 32'(busy1), 32'h0);
    tick(); idle();
    #1;
    check("stored_r3", 32'(reg1), 32'hBEEF);

    // Writes to R0 are discarded
    wb_en = 1'b1; rd_wb = 4'd0; wb_data = 16'h1234; rs2 = 4'd0;
    #1;
    check("r0_bypass_data", 32'(reg2), 32'h0);
    check("r0_bypass_busy", 32'(busy2), 32'h0);
    tick(); idle();
    #1;
    check("r0_stored_data", 32'(reg2), 32'h0);
    check("r0_stored_busy", 32'(busy2), 32'h0);
    check("r0_pending", 32'(pending), 32'h0);

    // Scoreboard counting
    issue_en = 1'b1; rd_issue = 4'd5;
    tick();
    check("pending_after_i5", 32'(pending), 32'd1);
    rd_issue = 4'd7;
    tick(); idle();
    check("pending_after_i7", 32'(pending), 32'd2);
    rs1 = 4'd5;
    #1;
    check("busy_r5", 32'(busy1), 32'h1);
    wb_en = 1'b1; rd_wb = 4'd5; wb_data = 16'h0055;
    #1;
    check("busy_r5_bypass", 32'(busy1), 32'h0);
    check("data_r5_bypass", 32'(reg1), 32'h0055);
    tick(); idle();
    check("pending_after_wb5", 32'(pending), 32'd1);
    check("busy_r5_cleared", 32'(busy1), 32'h0);

    // Same-cycle issue and writeback to a busy register
    issue_en = 1'b1; rd_issue = 4'd9;
    tick();
    check("pending_after_i9", 32'(pending), 32'd2);
    wb_en = 1'b1; rd_wb = 4'd9; wb_data = 16'h00AA; rs2 = 4'd9;
    tick(); idle();
    #1;
    check("same_cycle_pending", 32'(pending), 32'd2);
    check("same_cycle_busy9", 32'(busy2), 32'h1);
    check("same_cycle_r9", 32'(reg2), 32'h00AA);

    // Re-issue of an already busy register
    issue_en = 1'b1; rd_issue = 4'd7;
    tick(); idle();
    check("reissue_pending", 32'(pending), 32'd2);

    // Reset in the middle of a sweep restarts it
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("mid_sweep_not_ready", 32'(ready), 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("restart_pending", 32'(pending), 32'h0);
    sweep(cnt);
    check("restart_sweep_len", 32'(cnt), 32'd16);
    rs1 = 4'd3; rs2 = 4'd9;
    #1;
    check("restart_r3", 32'(reg1), 32'h0);
    check("restart_r9", 32'(reg2), 32'h0);
    check("restart_busy9", 32'(busy2), 32'h0);
    check("restart_pending_run", 32'(pending), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
